serial_alu: RTL and testbench

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu.sv | 196 +++++++++++++++++++
 tb/tb_serial_alu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// Bit-serial ALU: one operand bit per cycle, LSB first, through a single 1-bit slice with registered carry.
// Latency: done_out pulses WIDTH+1 cycles after the edge that accepts start_in; result_out held until the next start.
// Backpressure: start_in is ignored while busy_out is high. Flags are built only with SERIAL_ALU_FLAGS_EN defined.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             resetn_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       op_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cin_msb_q, cin_msb_d;
    logic               sum_msb_q, sum_msb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    logic               wa, wb, slice_sum, slice_res, slice_carry, last_bit;
    logic               ovf, set_bit;
    logic [WIDTH-1:0]   final_res;

    // State register; reset wins over everything, so a start during reset is dropped.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state: accept start in IDLE, walk the bits in RUN, one FINISH cycle to commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_in) state_d = S_RUN;
            S_RUN:    if (last_bit) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers RUN and FINISH; done and result come straight from registers.
    always_comb begin
        busy_out   = (state_q != S_IDLE);
        done_out   = done_q;
        result_out = result_q;
    end

    // Single 1-bit slice working on the LSB of the shifting operand registers.
    always_comb begin
        wa          = op_q[3] ^ a_q[0];
        wb          = op_q[2] ^ b_q[0];
        slice_sum   = wa ^ wb ^ carry_q;
        slice_carry = ((wa ^ wb) & carry_q) | (wa & wb);
        last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
        case (op_q[1:0])
            2'b00:   slice_res = wa & wb;
            2'b01:   slice_res = wa | wb;
            2'b10:   slice_res = slice_sum;
            default: slice_res = 1'b0;
        endcase
    end

    // Final result: SLT replaces bit 0 with the sign of the true difference; carry_q holds carry-out by now.
    always_comb begin
        ovf       = cin_msb_q ^ carry_q;
        set_bit   = sum_msb_q ^ ovf;
        final_res = acc_q;
        if (op_q[1:0] == 2'b11) final_res = {acc_q[WIDTH-1:1], set_bit};
    end

    // Datapath next-state: latch on start, shift one bit per RUN cycle, commit result in FINISH.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        cin_msb_d = cin_msb_q;
        sum_msb_d = sum_msb_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    op_d      = op_in;
                    carry_d   = op_in[2];
                    cnt_d     = '0;
                    acc_d     = '0;
                    cin_msb_d = 1'b0;
                    sum_msb_d = 1'b0;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = {slice_res, acc_q[WIDTH-1:1]};
                carry_d = slice_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cin_msb_d = carry_q;
                    sum_msb_d = slice_sum;
                end
            end
            S_FINISH: begin
                result_d = final_res;
                done_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers with synchronous active-low clear.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            cin_msb_q <= 1'b0;
            sum_msb_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            cin_msb_q <= cin_msb_d;
            sum_msb_q <= sum_msb_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q, zero_d, cflag_q, cflag_d, ovf_q, ovf_d;

    // Flags are formed in FINISH alongside the result; carry/overflow only mean something for add-type ops.
    always_comb begin
        zero_d  = zero_q;
        cflag_d = cflag_q;
        ovf_d   = ovf_q;
        if (state_q == S_FINISH) begin
            zero_d  = (final_res == '0);
            cflag_d = op_q[1] & carry_q;
            ovf_d   = op_q[1] & ovf;
        end
    end

    // Flag registers.
    always_ff @(posedge clk_in) begin
        if (!resetn_in) begin
            zero_q  <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            cflag_q <= cflag_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zero_out     = zero_q;
    assign carry_out    = cflag_q;
    assign overflow_out = ovf_q;
`else
    assign zero_out     = 1'b0;
    assign carry_out    = 1'b0;
    assign overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Testbench for serial_alu (WIDTH=8): randomized ops against an arithmetic reference model.
// Latency: every op is expected to report done 9 cycles after the accepting edge.
// Backpressure: stray start pulses during busy must be ignored; flag expectations follow SERIAL_ALU_FLAGS_EN.
module tb_serial_alu;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         resetn_in;
    logic         start_in;
    logic [W-1:0] a_in, b_in;
    logic [3:0]   op_in;
    logic         busy_out, done_out, zero_out, carry_out, overflow_out;
    logic [W-1:0] result_out;

    int checks = 0;
    int errors = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk_in       (clk_in),
        .resetn_in    (resetn_in),
        .start_in     (start_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .op_in        (op_in),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .result_out   (result_out),
        .zero_out     (zero_out),
        .carry_out    (carry_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain two's-complement arithmetic on the (optionally inverted) operands.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic z, output logic c, output logic v);
        logic [7:0] wa, wb;
        logic [8:0] s;
        int sa, sb, ss;
        wa = op[3] ? ~a : a;
        wb = op[2] ? ~b : b;
        s  = {1'b0, wa} + {1'b0, wb} + {8'd0, op[2]};
        sa = int'($signed(wa));
        sb = int'($signed(wb));
        ss = sa + sb + (op[2] ? 1 : 0);
        v  = (ss > 127) || (ss < -128);
        c  = s[8];
        case (op[1:0])
            2'b00:   r = wa & wb;
            2'b01:   r = wa | wb;
            2'b10:   r = s[7:0];
            default: r = {7'd0, s[7] ^ v};
        endcase
        if (!op[1]) begin
            c = 1'b0;
            v = 1'b0;
        end
        z = (r == 8'd0);
`ifndef SERIAL_ALU_FLAGS_EN
        z = 1'b0;
        c = 1'b0;
        v = 1'b0;
`endif
    endfunction

    // Cycle model: an op occupies W+1 cycles after acceptance, then outputs update with a done pulse.
    int           m_rem = 0;
    logic         m_live = 1'b0;
    logic         m_done = 1'b0;
    logic [7:0]   m_res = 8'd0, p_res = 8'd0;
    logic         m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
    logic         p_z = 1'b0, p_c = 1'b0, p_v = 1'b0;

    always @(posedge clk_in) begin : mdl
        logic [7:0] r;
        logic z, c, v;
        m_live <= 1'b1;
        if (!resetn_in) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_res  <= 8'd0;
            m_z    <= 1'b0;
            m_c    <= 1'b0;
            m_v    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start_in) begin
                    model(op_in, a_in, b_in, r, z, c, v);
                    p_res <= r;
                    p_z   <= z;
                    p_c   <= c;
                    p_v   <= v;
                    m_rem <= W + 1;
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    m_res  <= p_res;
                    m_z    <= p_z;
                    m_c    <= p_c;
                    m_v    <= p_v;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_in) begin
        if (m_live) begin
            chk1("busy", busy_out, m_rem != 0);
            chk1("done", done_out, m_done);
            chk8("result", result_out, m_res);
            chk1("zero", zero_out, m_z);
            chk1("carry", carry_out, m_c);
            chk1("overflow", overflow_out, m_v);
        end
    end

    // Issue one op and wait for done; optionally pulse a stray start at cycle 'poke' of the op.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int poke);
        int lat;
        start_in = 1'b1;
        op_in    = op;
        a_in     = a;
        b_in     = b;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        a_in     = 8'($urandom);
        b_in     = 8'($urandom);
        op_in    = 4'($urandom);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (poke != 0 && i == poke) start_in = 1'b1;
            if (poke != 0 && i == poke + 1) start_in = 1'b0;
            @(posedge clk_in);
            #1;
            if (done_out === 1'b1) begin
                lat = i;
                break;
            end
        end
        start_in = 1'b0;
        chk8("latency", 8'(lat), 8'(W + 1));
    endtask

    // Pin both the model and the DUT to hand-computed values.
    task automatic lit(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic ez, input logic ec, input logic ev);
        logic [7:0] r;
        logic z, c, v;
`ifndef SERIAL_ALU_FLAGS_EN
        ez = 1'b0;
        ec = 1'b0;
        ev = 1'b0;
`endif
        model(op, a, b, r, z, c, v);
        chk8({name, "_model_res"}, r, er);
        chk1({name, "_model_ovf"}, v, ev);
        chk8({name, "_res"}, result_out, er);
        chk1({name, "_zero"}, zero_out, ez);
        chk1({name, "_carry"}, carry_out, ec);
        chk1({name, "_ovf"}, overflow_out, ev);
    endtask

    initial begin
        logic saw_done;
        resetn_in = 1'b0;
        start_in  = 1'b1;
        a_in      = 8'h55;
        b_in      = 8'h33;
        op_in     = 4'b0010;
        repeat (3) @(posedge clk_in);
        #1;
        chk1("rst_busy", busy_out, 1'b0);
        chk1("rst_done", done_out, 1'b0);
        chk8("rst_result", result_out, 8'h00);
        start_in  = 1'b0;
        resetn_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Directed cases, issued back-to-back (each start lands in the done cycle of the previous op).
        do_op(4'b0010, 8'h7F, 8'h01, 0);
        lit("add", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        do_op(4'b0110, 8'h05, 8'h05, 0);
        lit("sub", 4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
        do_op(4'b0111, 8'h80, 8'h01, 0);
        lit("slt1", 4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
        do_op(4'b0111, 8'h01, 8'h80, 0);
        lit("slt0", 4'b0111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op(4'b1100, 8'hF0, 8'h0C, 0);
        lit("nor", 4'b1100, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0);
        do_op(4'b0001, 8'hF0, 8'h0C, 3);
        lit("or_poke", 4'b0001, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of an op: abort with no done pulse.
        start_in = 1'b1;
        op_in    = 4'b0010;
        a_in     = 8'h12;
        b_in     = 8'h34;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        resetn_in = 1'b0;
        @(posedge clk_in);
        #1;
        chk1("midrst_busy", busy_out, 1'b0);
        chk8("midrst_result", result_out, 8'h00);
        chk1("midrst_done", done_out, 1'b0);
        resetn_in = 1'b1;
        saw_done  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in);
            #1;
            if (done_out === 1'b1) saw_done = 1'b1;
        end
        chk1("midrst_no_done", saw_done, 1'b0);

        // Randomized ops with occasional stray starts and idle gaps.
        for (int n = 0; n < 150; n++) begin
            int poke;
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            do_op(4'($urandom), 8'($urandom), 8'($urandom), poke);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_in);
                #1;
            end
        end

        repeat (2) @(posedge clk_in);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
